// File: rtl/alu_cc_writeback.sv
// ALU writeback: result FIFO, SPARC icc register and Bicc evaluation.
// Optional macro ALU_CC_WRITEBACK_FORWARD_EN: branch sees next_icc.
//
// Ports:
//   clk, reset_n         clock, sync active-low reset
//   in_valid/in_ready    ALU result handshake
//   in_y, in_flags       result word and {N,Z,V,C}
//   in_opcode, in_rd     producing opcode, destination reg
//   in_setcc             cc-variant instruction
//   out_valid/out_ready  regfile writeback handshake
//   out_y, out_rd        FIFO head
//   icc                  condition codes {N,Z,V,C}
//   br_cond, br_taken    Bicc cond field and result

module alu_cc_writeback #(
  parameter int          DEPTH      = 2,
  parameter logic [15:0] CC_OP_MASK = 16'h00FF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_y,
  input  logic [3:0]  in_flags,
  input  logic [3:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic        in_setcc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_y,
  output logic [4:0]  out_rd,
  output logic [3:0]  icc,
  input  logic [3:0]  br_cond,
  output logic        br_taken
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  rd;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic          push;
  logic          pop;
  logic          cc_upd;
  logic [3:0]    next_icc;
  logic [3:0]    br_src;

  // Handshake. Ready ignores out_ready: no pass-through when full.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // %g0 is hardwired: handshake completes, nothing is queued.
  assign push   = accept && (in_rd != 5'd0);

  // icc update is independent of FIFO occupancy and of rd.
  assign cc_upd   = accept && in_setcc && CC_OP_MASK[in_opcode];
  assign next_icc = cc_upd ? in_flags : icc;

  // Head is gated so the outputs read zero while empty.
  assign head   = mem[rd_ptr];
  assign out_y  = out_valid ? head.y  : 32'd0;
  assign out_rd = out_valid ? head.rd : 5'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      icc    <= 4'b0000;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      icc <= next_icc;
    end
  end

  // Storage needs no reset: it is only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{y: in_y, rd: in_rd};
  end

`ifdef ALU_CC_WRITEBACK_FORWARD_EN
  assign br_src = next_icc;
`else
  assign br_src = icc;
`endif

  // Bicc: cond[2:0] selects the test, cond[3] inverts it.
  // cond 000 is "never", so its inverse 1000 is "always".
  always_comb begin
    logic n, z, v, c, base;
    n    = br_src[3];
    z    = br_src[2];
    v    = br_src[1];
    c    = br_src[0];
    base = 1'b0;
    unique case (br_cond[2:0])
      3'd0: base = 1'b0;
      3'd1: base = z;
      3'd2: base = z | (n ^ v);
      3'd3: base = n ^ v;
      3'd4: base = c | z;
      3'd5: base = c;
      3'd6: base = n;
      3'd7: base = v;
    endcase
    br_taken = base ^ br_cond[3];
  end

endmodule

// File: tb/tb_alu_cc_writeback.sv
// Bench for alu_cc_writeback: directed plan steps then random traffic.
// Reference: queue FIFO plus a Bicc truth table.

module tb_alu_cc_writeback;

  localparam int          DEPTH = 2;
  localparam logic [15:0] MASK  = 16'h00FF;

`ifdef ALU_CC_WRITEBACK_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic [3:0]  in_flags;
  logic [3:0]  in_opcode;
  logic [4:0]  in_rd;
  logic        in_setcc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_rd;
  logic [3:0]  icc;
  logic [3:0]  br_cond;
  logic        br_taken;

  alu_cc_writeback #(
    .DEPTH(DEPTH),
    .CC_OP_MASK(MASK)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_y(in_y),
    .in_flags(in_flags),
    .in_opcode(in_opcode),
    .in_rd(in_rd),
    .in_setcc(in_setcc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .out_rd(out_rd),
    .icc(icc),
    .br_cond(br_cond),
    .br_taken(br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  rd;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_icc;
  int         tests;
  int         fails;

  function automatic bit br_ref(input logic [3:0] c,
                                input logic [3:0] f);
    bit n, z, v, cy;
    n  = f[3];
    z  = f[2];
    v  = f[1];
    cy = f[0];
    case (c)
      4'b0000: return 1'b0;
      4'b1000: return 1'b1;
      4'b0001: return z;
      4'b1001: return !z;
      4'b0010: return z || (n != v);
      4'b1010: return !(z || (n != v));
      4'b0011: return n != v;
      4'b1011: return n == v;
      4'b0100: return cy || z;
      4'b1100: return !(cy || z);
      4'b0101: return cy;
      4'b1101: return !cy;
      4'b0110: return n;
      4'b1110: return !n;
      4'b0111: return v;
      default: return !v;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    m_icc = 4'b0000;
    #1;
    chk("rst_icc", 32'(icc), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
  endtask

  // One cycle: drive, check pre-edge outputs, clock, advance model.
  task automatic step(input logic        v,
                      input logic [31:0] y,
                      input logic [3:0]  f,
                      input logic [3:0]  op,
                      input logic [4:0]  rd,
                      input logic        sc,
                      input logic        ordy,
                      input logic [3:0]  bc);
    bit         e_rdy, e_ov, acc;
    logic [3:0] nicc;
    @(negedge clk);
    reset_n   = 1'b1;
    in_valid  = v;
    in_y      = y;
    in_flags  = f;
    in_opcode = op;
    in_rd     = rd;
    in_setcc  = sc;
    out_ready = ordy;
    br_cond   = bc;
    #1;
    e_rdy = q.size() < DEPTH;
    e_ov  = q.size() != 0;
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      chk("out_y", out_y, q[0].y);
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
    end
    chk("icc", 32'(icc), 32'(m_icc));
    acc  = v && e_rdy;
    nicc = (acc && sc && MASK[op]) ? f : m_icc;
    chk("br_taken", 32'(br_taken),
        32'(br_ref(bc, FWD ? nicc : m_icc)));
    @(posedge clk);
    if (e_ov && ordy)
      void'(q.pop_front());
    if (acc && rd != 5'd0)
      q.push_back('{y, rd});
    m_icc = nicc;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    m_icc     = 4'b0000;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_y      = '0;
    in_flags  = '0;
    in_opcode = '0;
    in_rd     = '0;
    in_setcc  = 1'b0;
    out_ready = 1'b0;
    br_cond   = '0;

    // Reset then a cc-setting op to r3.
    do_reset();
    step(1, 32'h0, 4'b0100, 4'd0, 5'd3, 1, 0, 4'b0000);
    #1;
    chk("tp_icc_z", 32'(icc), 32'h4);
    chk("tp_out_rd3", 32'(out_rd), 32'd3);
    step(0, 32'h0, 4'b0000, 4'd0, 5'd0, 0, 1, 4'b0001);
    step(0, 32'h0, 4'b0000, 4'd0, 5'd0, 0, 1, 4'b0001);

    // Fill with out_ready low, then drain in order.
    step(1, 32'h11, 4'h0, 4'd9, 5'd1, 0, 0, 4'b1000);
    step(1, 32'h22, 4'h0, 4'd9, 5'd2, 0, 0, 4'b1000);
    #1;
    chk("full_ready_low", 32'(in_ready), 32'd0);
    step(1, 32'h33, 4'h0, 4'd9, 5'd3, 0, 0, 4'b1000);
    for (int i = 0; i < 5; i++)
      step(1, 32'h33, 4'h0, 4'd9, 5'd3, 0, 1, 4'b1000);
    for (int i = 0; i < 3; i++)
      step(0, 32'h0, 4'h0, 4'd0, 5'd0, 0, 1, 4'b0000);

    // Count held at one with push and pop every cycle.
    step(1, 32'hA0, 4'h0, 4'd9, 5'd4, 0, 0, 4'b0000);
    for (int i = 0; i < 8; i++)
      step(1, 32'hB0 + 32'(i), 4'h0, 4'd9, 5'(5 + i), 0, 1,
           4'b0000);
    for (int i = 0; i < 2; i++)
      step(0, 32'h0, 4'h0, 4'd0, 5'd0, 0, 1, 4'b0000);

    // %g0 write still updates icc.
    step(1, 32'hDEAD, 4'b1010, 4'd1, 5'd0, 1, 1, 4'b0000);
    #1;
    chk("g0_out_valid", 32'(out_valid), 32'd0);
    chk("g0_icc", 32'(icc), 32'hA);
    step(0, 32'h0, 4'h0, 4'd0, 5'd0, 0, 1, 4'b0011);
    step(0, 32'h0, 4'h0, 4'd0, 5'd0, 0, 1, 4'b0110);

    // Non-cc and masked opcodes leave icc alone.
    step(1, 32'h5, 4'b1111, 4'd2, 5'd5, 0, 1, 4'b0000);
    step(1, 32'h6, 4'b1111, 4'd8, 5'd6, 1, 1, 4'b0000);
    #1;
    chk("masked_icc", 32'(icc), 32'hA);

    // cc-to-branch timing.
    step(1, 32'h7, 4'b0001, 4'd0, 5'd7, 1, 1, 4'b0101);
    step(0, 32'h0, 4'h0, 4'd0, 5'd0, 0, 1, 4'b0101);
    #1;
    chk("fwd_next_cycle", 32'(br_taken), 32'd1);

    // Random traffic with occasional mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(63) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(3) != 0), $urandom,
             4'($urandom), 4'($urandom),
             ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom),
             1'($urandom), 1'($urandom_range(2) != 0),
             4'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cc_writeback.md
Name: alu_cc_writeback

Overview:
- Consumer end of the ALU interface. Accepts ALU results (y, flags, opcode, destination register) through a valid/ready handshake.
- Holds the SPARC integer condition codes (icc = {N,Z,V,C}) and updates them for cc-setting opcodes.
- Buffers results in a small FIFO ahead of register-file writeback.
- Evaluates the Bicc branch condition against icc for the fetch/branch unit.

Parameters:
- DEPTH, 2, FIFO entries (power of two, 2..8).
- CC_OP_MASK, 16'h00FF, bit k = 1 means ALU opcode k sets icc when in_setcc is high.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous reset, active-low
- in_valid  input  1  ALU result valid
- in_ready  output  1  block can accept this cycle
- in_y  input  32  ALU result
- in_flags  input  4  ALU flags {N,Z,V,C}
- in_opcode  input  4  ALU opcode that produced in_y
- in_rd  input  5  destination register
- in_setcc  input  1  instruction is a cc variant
- out_valid  output  1  FIFO head valid
- out_ready  input  1  register file accepts head
- out_y  output  32  head result
- out_rd  output  5  head destination
- icc  output  4  condition code register {N,Z,V,C}
- br_cond  input  4  Bicc cond field
- br_taken  output  1  branch condition true

Behaviour:
- Reset (reset_n low at posedge) sets:
  - icc = 4'b0000
  - FIFO count = 0, read and write pointers = 0
  - out_valid = 0, in_ready = 1
  - out_y and out_rd = 0
  - Reset mid-operation discards all buffered entries.
- Accept: in_valid && in_ready at posedge.
- in_ready = (count < DEPTH). The ready decision does not depend on out_ready, so there is no pass-through when full.
- Pop: out_valid && out_ready at posedge. out_valid = (count != 0). out_y and out_rd are driven combinationally from the FIFO head.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at every count, including full (in_ready already 0, so no push occurs) and empty (no pop occurs).
- Pointers wrap modulo DEPTH.
- Write latency: an accepted entry appears at out_valid one cycle after accept when the FIFO was empty.
- Register 0 (in_rd == 0): the entry is accepted (handshake completes) but not enqueued, because %g0 is hardwired. The icc update rule still applies.
- icc update: on accept, if in_setcc && CC_OP_MASK[in_opcode], then icc <= in_flags at that posedge. Otherwise icc holds. The update is independent of FIFO occupancy.
- br_taken: combinational from br_cond and icc (see Optional Feature for the source). Encoding:
  - 0000 never, 1000 always
  - 0001 Z, 1001 !Z
  - 0010 Z|(N^V), 1010 !(Z|(N^V))
  - 0011 N^V, 1011 !(N^V)
  - 0100 C|Z, 1100 !(C|Z)
  - 0101 C, 1101 !C
  - 0110 N, 1110 !N
  - 0111 V, 1111 !V
- No X on outputs after reset. Inputs other than in_valid are ignored when in_valid is 0.

Optional Feature:
- Macro: ALU_CC_WRITEBACK_FORWARD_EN.
- Defined: br_taken is evaluated on next_icc. next_icc = in_flags when an icc-updating accept occurs this cycle, otherwise icc. A branch in the same cycle as a cc-setting ALU op sees the new flags with zero bubble.
- Undefined: br_taken is evaluated on the registered icc only, giving a one-cycle cc-to-branch latency. The branch unit must stall one cycle after a cc-setting op.

Test Plan:
- Reset, then set cc: assert reset_n=0 for 2 cycles, then accept y=32'h0000_0000, flags=4'b0100, opcode=0, setcc=1, rd=3 -> next cycle icc=0100, out_valid=1, out_y=0, out_rd=3; br_cond=0001 gives br_taken=1.
- Fill and backpressure: hold out_ready=0, push 3 results with rd=1,2,3 (DEPTH=2) -> in_ready=0 after 2 accepts. Raise out_ready -> outputs rd=1 then rd=2 in order; the third push is accepted when count drops.
- Simultaneous push/pop at count=1: out_ready=1, in_valid=1 each cycle for 8 cycles -> count stays 1, the output order matches the input order, and the pointers wrap correctly.
- Register-0 write: rd=0, setcc=1, flags=4'b1010 -> accepted, out_valid stays 0, icc=1010; br_cond=0011 gives br_taken=0 (N^V=0), br_cond=0110 gives br_taken=1.
- Non-cc and masked opcodes: setcc=0 with flags=1111 -> icc unchanged. setcc=1 with opcode=8 and CC_OP_MASK=16'h00FF -> icc unchanged.
- Forwarding:
  - With ALU_CC_WRITEBACK_FORWARD_EN defined: accept flags=0001 with setcc and br_cond=0101 in the same cycle -> br_taken=1 in that cycle.
  - Without the macro: br_taken=0 in that cycle and 1 in the following cycle.
